// File: rtl/fmac_pkg.sv
// Shared types and constants for the FMAC accumulator slice.
package fmac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 18;
  localparam int LEN_W_DEF = 4;

endpackage

// File: rtl/fmac_sat_add.sv
// Signed accumulate step: acc + sign-extended product, overflow flag, optional clamp (FMAC_ACC_SATURATE_EN).
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle.
module fmac_sat_add
  import fmac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [PROD_W-1:0] prod_in,
  output logic [ACC_W-1:0]  sum_out,
  output logic              ovf_out
);

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] raw_sum;

  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};
    raw_sum  = acc_in + prod_ext;
    // Overflow only when both operands share a sign and the result flips it.
    ovf_out  = (acc_in[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (raw_sum[ACC_W-1] != acc_in[ACC_W-1]);
`ifdef FMAC_ACC_SATURATE_EN
    if (ovf_out) begin
      sum_out = acc_in[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum_out = raw_sum;
    end
`else
    sum_out = raw_sum;
`endif
  end

endmodule

// File: rtl/fmac_accumulator.sv
// Accumulates len+1 signed products into a sticky-overflow accumulator; saturation under FMAC_ACC_SATURATE_EN.
// Latency: acc_valid rises the cycle after the final product handshake.
// Backpressure: prod_ready only in ACCUM; result held in DONE until acc_ready.
module fmac_accumulator
  import fmac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              overflow,
  output logic              busy
);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  fmac_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc_in  (acc_q),
    .prod_in (prod_in),
    .sum_out (add_sum),
    .ovf_out (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    ovf_d      = ovf_q;
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          rem_d   = len;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        prod_ready = 1'b1;
        if (prod_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          // remaining counts products still owed after this one
          if (rem_q == '0) begin
            state_d = DONE;
          end else begin
            rem_d = rem_q - LEN_W'(1);
          end
        end
      end
      DONE: begin
        acc_valid = 1'b1;
        if (acc_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign acc_out  = acc_q;
  assign overflow = ovf_q;

endmodule
